nhr_output_arbiter: RTL and testbench

- Per-output-port controller in the NoC router arbiter.
- Shares one output port between NUM_REQ input buffers using round-robin, locked per packet.
- On each grant it loads the granted port's next-hop address through the next-hop register's write strobe.
- Paces the packet flit-by-flit and flags the last flit, so the next-hop register can fall back to the idle address (3'b011).

---
 rtl/noc_arb_pkg.sv | 40 ++++
 rtl/rr_priority_picker.sv | 51 +++++
 rtl/nhr_output_arbiter.sv | 133 +++++++++++++
 tb/tb_nhr_output_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_arb_pkg
// Description : Shared types and constants for the NoC output-port arbiter:
//               arbiter state encoding and next-hop register addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_arb_pkg;

  // Arbiter states: wait for a request, load next hop, move the packet
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  // Requester index width; covers up to five input buffers
  localparam int IDX_W = 3;

  // Next-hop register address codes
  localparam logic [2:0] ADDR_N    = 3'b000;
  localparam logic [2:0] ADDR_E    = 3'b001;
  localparam logic [2:0] ADDR_S    = 3'b010;
  localparam logic [2:0] IDLE_ADDR = 3'b011;
  localparam logic [2:0] ADDR_W    = 3'b100;
  localparam logic [2:0] ADDR_L    = 3'b101;

  // Address per requester index, in N,E,S,W,L order
  localparam logic [2:0] PORT_ADDR [5] = '{ADDR_N, ADDR_E, ADDR_S, ADDR_W, ADDR_L};

  // Map a requester index to its next-hop address; out-of-range maps to idle
  function automatic logic [2:0] port_addr(input logic [IDX_W-1:0] idx);
    logic [2:0] a;
    a = IDLE_ADDR;
    if (idx < 3'd5) a = PORT_ADDR[idx];
    return a;
  endfunction

endpackage : noc_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or after ptr_i, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic [IDX_W-1:0]   winner_idx_o,
  output logic               any_o
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

  // Requests widened to the full index range so any index value is in bounds
  logic [(1<<IDX_W)-1:0] req_ext;
  logic [(1<<IDX_W)-1:0] oh_ext;
  logic [IDX_W:0]        sum;
  logic [IDX_W-1:0]      cand;

  assign req_ext     = (1<<IDX_W)'(req_i);
  assign winner_oh_o = oh_ext[NUM_REQ-1:0];

  // Walk candidates ptr, ptr+1, ... (wrapped) and keep the first requester
  always_comb begin
    oh_ext       = '0;
    winner_idx_o = '0;
    any_o        = 1'b0;
    sum          = '0;
    cand         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= NUM_W) sum = sum - NUM_W;
      cand = sum[IDX_W-1:0];
      if (!any_o && req_ext[cand]) begin
        any_o        = 1'b1;
        winner_idx_o = cand;
        oh_ext[cand] = 1'b1;
      end
    end
  end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/nhr_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nhr_output_arbiter
// Description : Per-output-port controller. Round-robin grant locked for a
//               whole packet, next-hop register load on grant, flit pacing
//               and last-flit signalling with fallback to the idle address.
// Revision    : 1.0 - initial release
// ============================================================================
module nhr_output_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] ib_empty_i,
  input  logic               ready_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] ib_read_o,
  output logic               xfer_o,
  output logic               pt_almost_done_o,
  output logic               nhr_write_o,
  output logic [2:0]         nhr_address_o,
  output logic               busy_o
);

  localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q,  state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [NUM_REQ-1:0] grant_q,  grant_d;
  logic [2:0]         addr_q,   addr_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               xfer;
  logic               last_flit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i        (req_i),
    .ptr_i        (rr_ptr_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx),
    .any_o        (pick_any)
  );

  assign grant_o          = grant_q;
  assign xfer_o           = xfer;
  assign ib_read_o        = grant_q & {NUM_REQ{xfer}};
  assign pt_almost_done_o = last_flit;
  assign busy_o           = (state_q != IDLE);

  // Next-state, grant lock, flit pacing and next-hop register strobes
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    winner_d      = winner_q;
    count_d       = count_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    xfer          = 1'b0;
    last_flit     = 1'b0;
    nhr_write_o   = 1'b0;
    nhr_address_o = addr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = LOAD;
          grant_d  = pick_oh;
          winner_d = pick_idx;
        end
      end
      LOAD: begin
        nhr_write_o   = 1'b1;
        nhr_address_o = port_addr(winner_q);
        addr_d        = port_addr(winner_q);
        count_d       = PKT_LEN_C;
        state_d       = XFER;
      end
      XFER: begin
        // Only the granted buffer's empty flag matters
        xfer      = ready_i & ~|(ib_empty_i & grant_q);
        last_flit = (count_q == CNT_ONE);
        if (xfer) begin
          count_d = count_q - CNT_ONE;
          if (last_flit) begin
            state_d       = IDLE;
            grant_d       = '0;
            rr_ptr_d      = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
            nhr_write_o   = 1'b1;
            nhr_address_o = IDLE_ADDR;
            addr_d        = IDLE_ADDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      addr_q   <= IDLE_ADDR;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
    end
  end

endmodule : nhr_output_arbiter
`default_nettype wire

// File: tb/tb_nhr_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nhr_output_arbiter
// Description : Self-checking bench for nhr_output_arbiter: directed scenarios
//               plus randomized traffic against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nhr_output_arbiter;

  localparam int NR = 5;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_i;
  logic [NR-1:0] ib_empty_i;
  logic          ready_i;
  logic [NR-1:0] grant_o;
  logic [NR-1:0] ib_read_o;
  logic          xfer_o;
  logic          pt_almost_done_o;
  logic          nhr_write_o;
  logic [2:0]    nhr_address_o;
  logic          busy_o;

  nhr_output_arbiter #(
    .NUM_REQ (NR),
    .PKT_LEN (PL),
    .CNT_W   (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_i            (req_i),
    .ib_empty_i       (ib_empty_i),
    .ready_i          (ready_i),
    .grant_o          (grant_o),
    .ib_read_o        (ib_read_o),
    .xfer_o           (xfer_o),
    .pt_almost_done_o (pt_almost_done_o),
    .nhr_write_o      (nhr_write_o),
    .nhr_address_o    (nhr_address_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which port owns the link, whether it is in its address
  // load cycle, flits still owed, round-robin start point, held address.
  int         m_owner = -1;
  bit         m_load  = 1'b0;
  int         m_rem   = 0;
  int         m_ptr   = 0;
  logic [2:0] m_addr  = 3'b011;
  logic [2:0] addr_tbl [NR] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  // Observed grant sequence and per-port read tallies taken from DUT outputs
  int            dut_log[$];
  int            rd_count[NR];
  logic [NR-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [NR-1:0] rq,
                       input logic [NR-1:0] em, input logic rd);
    reset      = r;
    req_i      = rq;
    ib_empty_i = em;
    ready_i    = rd;
  endtask

  task automatic clear_logs();
    dut_log.delete();
    for (int p = 0; p < NR; p++) rd_count[p] = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model
  task automatic tick(input string tag);
    logic          e_busy, e_xfer, e_almost, e_wr;
    logic [NR-1:0] e_grant, e_read;
    logic [2:0]    e_addr;
    bit            found;
    #1;
    e_busy  = (m_owner >= 0);
    e_grant = '0;
    e_xfer  = 1'b0;
    if (e_busy) begin
      e_grant = NR'(1 << m_owner);
      e_xfer  = !m_load && ready_i && !ib_empty_i[m_owner[2:0]];
    end
    e_read   = e_xfer ? e_grant : '0;
    e_almost = e_busy && !m_load && (m_rem == 1);
    e_wr     = m_load || (e_xfer && m_rem == 1);
    if (m_load)    e_addr = addr_tbl[m_owner];
    else if (e_wr) e_addr = 3'b011;
    else           e_addr = m_addr;

    check({tag, ".grant"},  8'(grant_o),          8'(e_grant));
    check({tag, ".read"},   8'(ib_read_o),        8'(e_read));
    check({tag, ".xfer"},   8'(xfer_o),           8'(e_xfer));
    check({tag, ".almost"}, 8'(pt_almost_done_o), 8'(e_almost));
    check({tag, ".nhr_wr"}, 8'(nhr_write_o),      8'(e_wr));
    check({tag, ".nhr_ad"}, 8'(nhr_address_o),    8'(e_addr));
    check({tag, ".busy"},   8'(busy_o),           8'(e_busy));
    check({tag, ".onehot"}, 8'($onehot0(grant_o)), 8'(1));
    check({tag, ".rd_empty"}, 8'(ib_read_o & ib_empty_i), 8'(0));

    if (grant_o != '0 && prev_grant == '0)
      for (int p = 0; p < NR; p++) if (grant_o[p]) dut_log.push_back(p);
    prev_grant = grant_o;
    for (int p = 0; p < NR; p++) if (ib_read_o[p]) rd_count[p]++;

    @(posedge clk);
    if (!reset) begin
      m_owner = -1; m_load = 1'b0; m_rem = 0; m_ptr = 0; m_addr = 3'b011;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (!found && req_i[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_load  = 1'b1;
        end
      end
    end else if (m_load) begin
      m_load = 1'b0;
      m_rem  = PL;
      m_addr = addr_tbl[m_owner];
    end else if (e_xfer) begin
      m_rem--;
      if (m_rem == 0) begin
        m_addr  = 3'b011;
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int ready_pat [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
    drive(1'b0, '1, '0, 1'b1);
    @(negedge clk);

    // Reset held with all requests, then full round-robin rotation
    tick("rst0");
    tick("rst1");
    clear_logs();
    drive(1'b1, 5'b11111, '0, 1'b1);
    for (int i = 0; i < 40; i++) tick("rr5");
    check("rr5.npkts", 8'(dut_log.size() >= 6), 8'(1));
    for (int i = 0; i < 6; i++) check("rr5.order", 8'(dut_log[i]), 8'(i % NR));

    // Single requester W
    drive(1'b0, '0, '0, 1'b1);
    tick("rstW");
    clear_logs();
    drive(1'b1, 5'b01000, '0, 1'b1);
    for (int i = 0; i < 6; i++) tick("onlyW");
    check("onlyW.reads", 8'(rd_count[3]), 8'(PL));
    drive(1'b1, 5'b00000, '0, 1'b1);
    tick("onlyW.tail");

    // Downstream backpressure pattern
    drive(1'b0, '0, '0, 1'b1);
    tick("rstR");
    clear_logs();
    drive(1'b1, 5'b00001, '0, 1'b1);
    tick("rdy.idle");
    tick("rdy.load");
    for (int i = 0; i < 9; i++) begin
      ready_i = ready_pat[i][0];
      req_i   = 5'b00000;
      tick("rdy.pat");
    end
    check("rdy.reads", 8'(rd_count[0]), 8'(PL));

    // Granted buffer runs dry while another port requests
    drive(1'b0, '0, '0, 1'b1);
    tick("rstE");
    clear_logs();
    drive(1'b1, 5'b00010, '0, 1'b1);
    for (int i = 0; i < 4; i++) tick("empty.pre");
    drive(1'b1, 5'b00100, 5'b00010, 1'b1);
    for (int i = 0; i < 3; i++) tick("empty.hold");
    drive(1'b1, 5'b00100, '0, 1'b1);
    for (int i = 0; i < 5; i++) tick("empty.post");
    check("empty.reads1", 8'(rd_count[1]), 8'(PL));
    check("empty.order", 8'(dut_log.size() == 2 && dut_log[0] == 1 && dut_log[1] == 2), 8'(1));

    // Reset in the middle of a packet (count 2)
    drive(1'b0, '0, '0, 1'b1);
    tick("rstM");
    clear_logs();
    drive(1'b1, 5'b11111, '0, 1'b1);
    for (int i = 0; i < 4; i++) tick("mid.pre");
    drive(1'b0, 5'b11111, '0, 1'b1);
    tick("mid.rst");
    drive(1'b1, 5'b11111, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick("mid.post");
    check("mid.order", 8'(dut_log.size() == 2 && dut_log[0] == 0 && dut_log[1] == 0), 8'(1));

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 63) != 0), NR'($urandom),
            NR'($urandom & $urandom), ($urandom_range(0, 3) != 0));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nhr_output_arbiter
`default_nettype wire
